// File: rtl/ballot_unit_if.sv
// Handshake bundle between the voter console, its stimulus side and the EVM counter.
// master drives arm/btn; slave is the ballot_unit itself.
interface ballot_unit_if;
    logic       arm;
    logic [3:0] btn;
    logic [1:0] candidate;
    logic       vote;
    logic       ready;
    logic       multi_press;
    logic       timeout;
    logic [7:0] cast_count;

    modport master (
        output arm, btn,
        input  candidate, vote, ready, multi_press, timeout, cast_count
    );

    modport slave (
        input  arm, btn,
        output candidate, vote, ready, multi_press, timeout, cast_count
    );
endinterface

// File: rtl/ballot_unit.sv
// Voter console: synchronises/debounces four buttons and emits one vote strobe per armed ballot.
// Optional armed-ballot expiry is enabled by defining BALLOT_TIMEOUT_EN.
module ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic          clk,
    input  logic          reset,
    ballot_unit_if.slave  bus
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ballot_unit: DEBOUNCE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DEBOUNCE,
        S_CAST,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          meta_q, meta_d;
    logic [3:0]          sbtn_q, sbtn_d;
    logic                clean_q, clean_d;
    logic                multi_seen_q, multi_seen_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [1:0]          code_q, code_d;
    logic [1:0]          cand_q, cand_d;
    logic [7:0]          count_q, count_d;
    logic [1:0]          enc;
    logic                onehot;
    logic                multi;
    logic                multi_press;

`ifdef BALLOT_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                timeout_q, timeout_d;
`endif

    assign meta_d = bus.btn;
    assign sbtn_d = meta_q;
    assign onehot = $onehot(sbtn_q);
    assign multi  = ($countones(sbtn_q) > 1);

    always_comb begin
        enc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sbtn_q[i]) enc = 2'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        clean_d      = clean_q;
        dcnt_d       = dcnt_q;
        code_d       = code_q;
        cand_d       = cand_q;
        count_d      = count_q;
        multi_press  = 1'b0;
        // Re-arms the multi-press pulse as soon as the multi-bit condition ends.
        multi_seen_d = multi ? multi_seen_q : 1'b0;
`ifdef BALLOT_TIMEOUT_EN
        tcnt_d       = tcnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.arm) begin
                    state_d      = S_ARMED;
                    clean_d      = 1'b0;
                    dcnt_d       = '0;
                    multi_seen_d = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
                    tcnt_d       = '0;
`endif
                end
            end
            S_ARMED: begin
                if (sbtn_q == 4'b0000) begin
                    clean_d = 1'b1;
                end else if (clean_q && onehot) begin
                    code_d  = enc;
                    dcnt_d  = DCNT_W'(1);
                    state_d = S_DEBOUNCE;
                end else if (clean_q && multi && !multi_seen_q) begin
                    multi_press  = 1'b1;
                    multi_seen_d = 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (sbtn_q == (4'b0001 << code_q)) begin
                    if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES)) begin
                        state_d = S_CAST;
                        cand_d  = code_q;
                        count_d = (count_q != 8'hFF) ? count_q + 8'd1 : count_q;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end else begin
                    state_d = S_ARMED;
                    dcnt_d  = '0;
                end
            end
            S_CAST: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // A still-held press must never reach a fresh ballot.
                if (sbtn_q == 4'b0000) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef BALLOT_TIMEOUT_EN
        if (state_q == S_ARMED || state_q == S_DEBOUNCE) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            // A cast landing on the expiry edge takes precedence over the timeout.
            if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1) && state_d != S_CAST) begin
                state_d   = S_IDLE;
                timeout_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            meta_q       <= 4'b0000;
            sbtn_q       <= 4'b0000;
            clean_q      <= 1'b0;
            multi_seen_q <= 1'b0;
            dcnt_q       <= '0;
            code_q       <= 2'b00;
            cand_q       <= 2'b00;
            count_q      <= 8'd0;
`ifdef BALLOT_TIMEOUT_EN
            tcnt_q       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            meta_q       <= meta_d;
            sbtn_q       <= sbtn_d;
            clean_q      <= clean_d;
            multi_seen_q <= multi_seen_d;
            dcnt_q       <= dcnt_d;
            code_q       <= code_d;
            cand_q       <= cand_d;
            count_q      <= count_d;
`ifdef BALLOT_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign bus.candidate   = cand_q;
    assign bus.vote        = (state_q == S_CAST);
    assign bus.ready       = (state_q == S_ARMED) || (state_q == S_DEBOUNCE);
    assign bus.multi_press = multi_press;
    assign bus.cast_count  = count_q;
`ifdef BALLOT_TIMEOUT_EN
    assign bus.timeout     = timeout_q;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_unit.sv
// Scoreboard bench for ballot_unit: the driver predicts each vote (cycle, code, count)
// from the ballot rules and a negedge monitor pops and compares whenever vote is seen.
module tb_ballot_unit;
    localparam int DEB = 4;
    localparam int TMO = 64;
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ballot_unit_if bus();

    ballot_unit #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int         at;
        logic [1:0] cand;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         mp_seen = 0;
    int         to_seen = 0;
    int         model_count = 0;
    int         model_mp = 0;
    logic [1:0] cur_cand = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1) << i;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick(1);
        bus.arm = 1'b0;
    endtask

    // Called on the negedge where a clean one-hot press is applied.
    task automatic expect_vote(input int idx);
        exp_t e;
        model_count = (model_count < 255) ? model_count + 1 : 255;
        e.at   = cyc + LAT;
        e.cand = 2'(idx);
        e.cnt  = 8'(model_count);
        sb.push_back(e);
    endtask

    task automatic press_vote(input int idx, input int hold);
        bus.btn = oh(idx);
        expect_vote(idx);
        tick(hold);
        bus.btn = 4'b0000;
        tick(4);
    endtask

    // Monitor: pops a prediction on every vote strobe and checks stability otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.multi_press === 1'b1) mp_seen++;
            if (bus.timeout === 1'b1) to_seen++;
            if (bus.vote === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_vote: got vote with candidate %0d, required none (cycle %0d)",
                             bus.candidate, cyc);
                end else begin
                    e = sb.pop_front();
                    check("vote_cycle", cyc, e.at);
                    check("vote_candidate", bus.candidate, e.cand);
                    check("vote_count", bus.cast_count, e.cnt);
                    check("ready_low_on_vote", bus.ready, 0);
                    cur_cand = e.cand;
                end
            end else begin
                check("candidate_held", bus.candidate, cur_cand);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         idx;
        int         j;
        int         nb;
        logic [3:0] m;

        bus.arm = 1'b0;
        bus.btn = 4'b0000;
        reset   = 1'b1;
        tick(3);
        check("rst_candidate", bus.candidate, 0);
        check("rst_vote", bus.vote, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_multi", bus.multi_press, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_count", bus.cast_count, 0);
        reset = 1'b0;
        tick(2);

        // Reset while debouncing: no vote, count stays 0.
        do_arm();
        tick(2);
        bus.btn = 4'b0001;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("mid_rst_vote", bus.vote, 0);
        check("mid_rst_ready", bus.ready, 0);
        check("mid_rst_count", bus.cast_count, 0);
        check("mid_rst_candidate", bus.candidate, 0);
        check("mid_rst_multi", bus.multi_press, 0);
        bus.btn = 4'b0000;
        reset   = 1'b0;
        tick(4);

        // Long hold of btn[2]: one vote only, IDLE after release.
        do_arm();
        check("arm_ready", bus.ready, 1);
        tick(2);
        press_vote(2, 20);
        check("idle_after_release", bus.ready, 0);
        check("count_after_first", bus.cast_count, model_count);

        // Button held through arm is never accepted until released.
        bus.btn = 4'b0010;
        tick(3);
        do_arm();
        tick(12);
        check("held_at_arm_waits", bus.ready, 1);
        bus.btn = 4'b0000;
        tick(4);
        press_vote(3, 15);

        // Two buttons: one multi_press pulse, then a single press votes.
        do_arm();
        tick(2);
        bus.btn = 4'b0011;
        model_mp++;
        tick(6);
        check("multi_pulse_count", mp_seen, model_mp);
        check("multi_still_armed", bus.ready, 1);
        press_vote(0, 15);

        // Bouncing btn[2] in 2-cycle pulses never reaches a vote.
        do_arm();
        tick(2);
        repeat (3) begin
            bus.btn = 4'b0100;
            tick(2);
            bus.btn = 4'b0000;
            tick(2);
        end
        check("bounce_still_armed", bus.ready, 1);
        press_vote(2, 15);

        // Randomised ballots with bounces, multi-presses and stray arm pulses.
        for (int it = 0; it < 12; it++) begin
            idx = $urandom_range(0, 3);
            do_arm();
            tick($urandom_range(2, 5));
            nb = $urandom_range(0, 2);
            repeat (nb) begin
                bus.btn = oh(idx);
                tick($urandom_range(1, 3));
                bus.btn = 4'b0000;
                tick($urandom_range(1, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                j = (idx + 1 + $urandom_range(0, 2)) % 4;
                m = oh(idx) | oh(j);
                bus.btn = m;
                model_mp++;
                tick($urandom_range(2, 5));
            end
            bus.btn = oh(idx);
            expect_vote(idx);
            if ($urandom_range(0, 1) == 1) begin
                tick($urandom_range(11, 17));
                do_arm();
                tick(2);
            end else begin
                tick($urandom_range(11, 20));
            end
            bus.btn = 4'b0000;
            tick($urandom_range(4, 7));
            check("rand_multi_count", mp_seen, model_mp);
            check("rand_idle", bus.ready, 0);
        end

        // Armed ballot with no press.
        do_arm();
`ifdef BALLOT_TIMEOUT_EN
        tick(TMO + 6);
        check("timeout_pulses", to_seen, 1);
        check("timeout_ready", bus.ready, 0);
`else
        tick(200);
        check("no_timeout_ready", bus.ready, 1);
        check("no_timeout_pulses", to_seen, 0);
`endif
        tick(10);
        check("scoreboard_empty", sb.size(), 0);
        check("final_count", bus.cast_count, model_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
